// File: rtl/systolic_data_feeder.sv
// systolic_data_feeder: loads a weight tile, then streams diagonally skewed activations into the array.
// Optional FEEDER_BUBBLE_COUNT_EN adds a saturating bubble_count output.
module systolic_data_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 2,
  parameter int COLUMNS    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [DATA_WIDTH*COLUMNS-1:0] w_vector,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH*ROWS-1:0]    in_vector,
  input  logic                          in_last,
  output logic [DATA_WIDTH*ROWS-1:0]    data,
  output logic [DATA_WIDTH*COLUMNS-1:0] weight,
  output logic                          store_weight,
  output logic                          busy,
`ifdef FEEDER_BUBBLE_COUNT_EN
  output logic [15:0]                   bubble_count,
`endif
  output logic                          tile_done
);
  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
  localparam int CW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
  localparam logic [CW-1:0] DRAIN_END = CW'(ROWS > 1 ? ROWS - 2 : 0);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH*COLUMNS-1:0] weight_q, weight_d;
  logic store_q, store_d, w_ready_q, w_ready_d, in_ready_q, in_ready_d;
  logic busy_q, busy_d, tile_done_q, tile_done_d;
  logic w_acc, in_acc;
  assign w_acc  = w_valid && w_ready_q;
  assign in_acc = in_valid && in_ready_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tile_done_d = 1'b0;
    case (state_q)
      IDLE: if (w_acc) begin
        cnt_d   = CW'(1);
        state_d = (ROWS == 1) ? STREAM : LOAD_W;
      end
      LOAD_W: if (w_acc) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST_ROW) ? STREAM : LOAD_W;
      end
      STREAM: if (in_acc && in_last) begin
        cnt_d       = '0;
        state_d     = (ROWS == 1) ? IDLE : DRAIN;
        tile_done_d = (ROWS == 1);
      end
      DRAIN: begin
        cnt_d       = cnt_q + 1'b1;
        state_d     = (cnt_q == DRAIN_END) ? IDLE : DRAIN;
        tile_done_d = (cnt_q == DRAIN_END);
      end
      default: state_d = IDLE;
    endcase
    weight_d   = w_acc ? w_vector : weight_q;
    store_d    = w_acc;
    w_ready_d  = (state_d == IDLE) || (state_d == LOAD_W);
    in_ready_d = (state_d == STREAM);
    busy_d     = (state_d != IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      weight_q    <= '0;
      store_q     <= 1'b0;
      w_ready_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      weight_q    <= weight_d;
      store_q     <= store_d;
      w_ready_q   <= w_ready_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
    end
  assign weight       = weight_q;
  assign store_weight = store_q;
  assign w_ready      = w_ready_q;
  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign tile_done    = tile_done_q;
  // Lane r is an (r+1)-deep shift register; newest element at the top, output at the bottom.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH*(r+1)-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] lane_in;
    assign lane_in = in_acc ? in_vector[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_head
      assign sr_d = lane_in;
    end else begin : g_tail
      assign sr_d = {lane_in, sr_q[DATA_WIDTH*(r+1)-1:DATA_WIDTH]};
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) sr_q <= '0;
      else sr_q <= sr_d;
    assign data[r*DATA_WIDTH +: DATA_WIDTH] = sr_q[DATA_WIDTH-1:0];
  end
`ifdef FEEDER_BUBBLE_COUNT_EN
  logic [15:0] bubble_q, bubble_d;
  always_comb
    bubble_d = (state_q == IDLE && w_acc) ? 16'h0000 :
               (state_q == STREAM && !in_valid && bubble_q != 16'hFFFF) ? bubble_q + 16'h0001 : bubble_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) bubble_q <= '0;
    else bubble_q <= bubble_d;
  assign bubble_count = bubble_q;
`endif
endmodule

// File: tb/tb_systolic_data_feeder.sv
// tb_systolic_data_feeder: directed 2x2 bench; expected data words are queued as stimulus is driven.
module tb_systolic_data_feeder;
  logic clk = 1'b0, rst;
  logic w_valid, w_ready, in_valid, in_ready, in_last;
  logic store_weight, busy, tile_done;
  logic [15:0] w_vector, in_vector, data, weight;
`ifdef FEEDER_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
`endif
  int n_assert = 0, n_fail = 0;
  logic [15:0] exp_q[$];

  systolic_data_feeder #(.DATA_WIDTH(8), .ROWS(2), .COLUMNS(2)) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w_vector(w_vector),
    .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector), .in_last(in_last),
    .data(data), .weight(weight), .store_weight(store_weight), .busy(busy),
`ifdef FEEDER_BUBBLE_COUNT_EN
    .bubble_count(bubble_count),
`endif
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) chk({tag, "_empty"}, 32'd1, 32'd0);
    else chk(tag, {16'h0, data}, {16'h0, exp_q.pop_front()});
  endtask

  // Rows (5,6) then (7,8); lane 0 in the low byte.
  task automatic load_weights;
    w_valid = 1'b1;
    w_vector = 16'h0605;
    tick;
    chk("w0_bus", {16'h0, weight}, 32'h0605);
    chk("w0_store", {31'h0, store_weight}, 32'd1);
    chk("w0_busy", {31'h0, busy}, 32'd1);
    chk("w0_in_ready", {31'h0, in_ready}, 32'd0);
    w_vector = 16'h0807;
    tick;
    chk("w1_bus", {16'h0, weight}, 32'h0807);
    chk("w1_store", {31'h0, store_weight}, 32'd1);
    chk("w1_in_ready", {31'h0, in_ready}, 32'd1);
    chk("w1_w_ready", {31'h0, w_ready}, 32'd0);
    chk("w1_no_data", {16'h0, data}, 32'h0);
    w_valid = 1'b0;
  endtask

  task automatic skew_tile;
    in_valid = 1'b1; in_vector = 16'h0201; in_last = 1'b0;
    exp_q.push_back(16'h0001);
    tick;
    pop_chk("skew_t1");
    chk("skew_store_idle", {31'h0, store_weight}, 32'd0);
    chk("skew_weight_hold", {16'h0, weight}, 32'h0807);
    in_vector = 16'h0403; in_last = 1'b1;
    exp_q.push_back(16'h0203);
    tick;
    pop_chk("skew_t2");
    chk("skew_t2_done", {31'h0, tile_done}, 32'd0);
    chk("skew_t2_in_ready", {31'h0, in_ready}, 32'd0);
    in_valid = 1'b0; in_last = 1'b0;
    exp_q.push_back(16'h0400);
    tick;
    pop_chk("skew_t3");
    chk("skew_t3_done", {31'h0, tile_done}, 32'd1);
    tick;
    chk("skew_t4_busy", {31'h0, busy}, 32'd0);
    chk("skew_t4_done", {31'h0, tile_done}, 32'd0);
    chk("skew_t4_data", {16'h0, data}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; w_valid = 1'b0; w_vector = '0; in_valid = 1'b0; in_vector = '0; in_last = 1'b0;
    tick; tick;
    chk("rst_data", {16'h0, data}, 32'h0);
    chk("rst_weight", {16'h0, weight}, 32'h0);
    chk("rst_ctrl", {27'h0, store_weight, w_ready, in_ready, busy, tile_done}, 32'h0);
    rst = 1'b0;
    tick;
    chk("rel_w_ready", {31'h0, w_ready}, 32'd1);
    chk("rel_busy", {31'h0, busy}, 32'd0);
    chk("rel_in_ready", {31'h0, in_ready}, 32'd0);
    load_weights;
    skew_tile;

    // Bubble tile with activations offered during loading and weights offered while streaming.
    in_valid = 1'b1; in_vector = 16'h0909; in_last = 1'b1;
    load_weights;
    w_valid = 1'b1; w_vector = 16'hBBAA;
    in_vector = 16'h0201; in_last = 1'b0;
    exp_q.push_back(16'h0001);
    tick;
    pop_chk("bub_t1");
    chk("bub_t1_store", {31'h0, store_weight}, 32'd0);
    in_valid = 1'b0;
    exp_q.push_back(16'h0200);
    tick;
    pop_chk("bub_t2");
    chk("bub_t2_store", {31'h0, store_weight}, 32'd0);
    in_valid = 1'b1; in_vector = 16'h0403; in_last = 1'b1;
    exp_q.push_back(16'h0003);
    tick;
    pop_chk("bub_t3");
    chk("bub_t3_done", {31'h0, tile_done}, 32'd0);
    in_valid = 1'b0; in_last = 1'b0;
    exp_q.push_back(16'h0400);
    tick;
    pop_chk("bub_t4");
    chk("bub_t4_done", {31'h0, tile_done}, 32'd1);
    chk("bub_weight_hold", {16'h0, weight}, 32'h0807);
    w_valid = 1'b0;
`ifdef FEEDER_BUBBLE_COUNT_EN
    chk("bub_count", {16'h0, bubble_count}, 32'd1);
`endif
    tick;
    chk("bub_idle_busy", {31'h0, busy}, 32'd0);
    chk("bub_idle_store", {31'h0, store_weight}, 32'd0);
`ifdef FEEDER_BUBBLE_COUNT_EN
    chk("bub_count_hold", {16'h0, bubble_count}, 32'd1);
`endif

    // Asynchronous reset while draining.
    load_weights;
    in_valid = 1'b1; in_vector = 16'h0201; in_last = 1'b0;
    tick;
    in_vector = 16'h0403; in_last = 1'b1;
    tick;
    chk("abort_pre", {16'h0, data}, 32'h0203);
    in_valid = 1'b0; in_last = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_data", {16'h0, data}, 32'h0);
    chk("abort_weight", {16'h0, weight}, 32'h0);
    chk("abort_ctrl", {27'h0, store_weight, w_ready, in_ready, busy, tile_done}, 32'h0);
    tick;
    chk("abort_no_done", {31'h0, tile_done}, 32'd0);
    chk("abort_data2", {16'h0, data}, 32'h0);
    rst = 1'b0;
    tick;
    chk("abort_w_ready", {31'h0, w_ready}, 32'd1);
    load_weights;
    skew_tile;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
